varredura_colunas: RTL and testbench



---
 rtl/varredura_colunas_if.sv | 33 +++
 rtl/varredura_colunas.sv | 120 ++++++++++++
 tb/tb_varredura_colunas.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/varredura_colunas_if.sv
// Column-scan bus for the LED matrix driver.
// Writer side drives enable/pattern; scanner drives the matrix pins.
interface varredura_colunas_if #(
  parameter int N_COLUNAS = 5,
  parameter int N_LINHAS  = 7
);
  localparam int IW = (N_COLUNAS > 1) ? $clog2(N_COLUNAS) : 1;

  logic                            habilitar;
  logic [N_COLUNAS*N_LINHAS-1:0]   dados_matriz;
  logic [N_COLUNAS-1:0]            colunas;
  logic [N_LINHAS-1:0]             linhas;
  logic [IW-1:0]                   coluna_atual;
  logic                            fim_quadro;

  modport master (
    output habilitar,
    output dados_matriz,
    input  colunas,
    input  linhas,
    input  coluna_atual,
    input  fim_quadro
  );

  modport slave (
    input  habilitar,
    input  dados_matriz,
    output colunas,
    output linhas,
    output coluna_atual,
    output fim_quadro
  );
endinterface

// File: rtl/varredura_colunas.sv
// Column-scan driver for the LED matrix.
// Snapshots the pattern per frame, lights one column at a time.
module varredura_colunas #(
  parameter int N_COLUNAS     = 5,
  parameter int N_LINHAS      = 7,
  parameter int TEMPO_APAGADO = 2,
  parameter int TEMPO_ACESO   = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  varredura_colunas_if.slave   bus
);
  localparam int NB   = N_COLUNAS * N_LINHAS;
  localparam int IW   = (N_COLUNAS > 1) ? $clog2(N_COLUNAS) : 1;
  localparam int TMAX = (TEMPO_APAGADO > TEMPO_ACESO) ?
                        TEMPO_APAGADO : TEMPO_ACESO;
  localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [CW-1:0] FIM_APAG = CW'(TEMPO_APAGADO - 1);
  localparam logic [CW-1:0] FIM_ACES = CW'(TEMPO_ACESO - 1);
  localparam logic [IW-1:0] ULTIMA   = IW'(N_COLUNAS - 1);
  localparam logic [N_COLUNAS-1:0] UM = N_COLUNAS'(1);

  typedef enum logic [1:0] {
    OCIOSO,
    APAGADO,
    ACESO
  } estado_t;

  estado_t             estado, prox_estado;
  logic [IW-1:0]       idx, prox_idx;
  logic [CW-1:0]       cnt, prox_cnt;
  logic [NB-1:0]       snap, prox_snap;
  logic [N_COLUNAS-1:0] col_q, prox_col;
  logic [N_LINHAS-1:0] lin_q, prox_lin;
  logic                fim_q, prox_fim;

  // State and registered outputs; reset forces the matrix dark at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado <= OCIOSO;
      idx    <= '0;
      cnt    <= '0;
      snap   <= '0;
      col_q  <= '0;
      lin_q  <= '1;
      fim_q  <= 1'b0;
    end else begin
      estado <= prox_estado;
      idx    <= prox_idx;
      cnt    <= prox_cnt;
      snap   <= prox_snap;
      col_q  <= prox_col;
      lin_q  <= prox_lin;
      fim_q  <= prox_fim;
    end
  end

  // Next state; column and rows are chosen together so no partial column shows.
  always_comb begin
    prox_estado = estado;
    prox_idx    = idx;
    prox_cnt    = cnt;
    prox_snap   = snap;
    prox_col    = '0;
    prox_lin    = '1;
    prox_fim    = 1'b0;
    if (!bus.habilitar) begin
      prox_estado = OCIOSO;
      prox_idx    = '0;
      prox_cnt    = '0;
    end else begin
      case (estado)
        OCIOSO: begin
          prox_snap   = bus.dados_matriz;
          prox_idx    = '0;
          prox_cnt    = '0;
          prox_estado = APAGADO;
        end
        APAGADO: begin
          if (cnt == FIM_APAG) begin
            prox_cnt    = '0;
            prox_estado = ACESO;
            prox_col    = UM << idx;
            prox_lin    = ~snap[idx*N_LINHAS +: N_LINHAS];
          end else begin
            prox_cnt = cnt + 1'b1;
          end
        end
        ACESO: begin
          if (cnt == FIM_ACES) begin
            prox_cnt    = '0;
            prox_estado = APAGADO;
            if (idx == ULTIMA) begin
              prox_idx  = '0;
              prox_snap = bus.dados_matriz;
              prox_fim  = 1'b1;
            end else begin
              prox_idx = idx + 1'b1;
            end
          end else begin
            prox_cnt = cnt + 1'b1;
            prox_col = col_q;
            prox_lin = lin_q;
          end
        end
        default: begin
          prox_estado = OCIOSO;
          prox_idx    = '0;
          prox_cnt    = '0;
        end
      endcase
    end
  end

  assign bus.colunas      = col_q;
  assign bus.linhas       = lin_q;
  assign bus.coluna_atual = idx;
  assign bus.fim_quadro   = fim_q;
endmodule

// File: tb/tb_varredura_colunas.sv
// Bench for the column-scan driver.
// Reference model tracks the position inside the frame arithmetically.
module tb_varredura_colunas;
  localparam int NC = 5;
  localparam int NL = 7;
  localparam int TA = 1;
  localparam int TL = 3;
  localparam int CP = TA + TL;
  localparam int FP = NC * CP;
  localparam int NB = NC * NL;

  logic clk = 1'b0;
  logic reset;
  logic [NB-1:0] dados;

  always #5 clk = ~clk;

  varredura_colunas_if #(.N_COLUNAS(NC), .N_LINHAS(NL)) vif();

  varredura_colunas #(
    .N_COLUNAS(NC),
    .N_LINHAS(NL),
    .TEMPO_APAGADO(TA),
    .TEMPO_ACESO(TL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(vif.slave)
  );

  int checks = 0;
  int errors = 0;
  bit running = 1'b0;
  int t = 0;
  bit fim_now = 1'b0;
  int pulses = 0;
  logic [NB-1:0] snap = '0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    logic [NC-1:0] ec;
    logic [NL-1:0] el;
    int ei;
    ec = '0;
    el = '1;
    ei = 0;
    if (running) begin
      ei = t / CP;
      if ((t % CP) >= TA) begin
        ec = NC'(1 << ei);
        el = ~snap[ei*NL +: NL];
      end
    end
    chk("colunas", 32'(vif.colunas), 32'(ec));
    chk("linhas", 32'(vif.linhas), 32'(el));
    chk("coluna_atual", 32'(vif.coluna_atual), 32'(ei));
    chk("fim_quadro", 32'(vif.fim_quadro), 32'(fim_now));
    chk("onehot", 32'($onehot0(vif.colunas)), 32'd1);
  endtask

  task automatic tick(bit hab);
    vif.habilitar    = hab;
    vif.dados_matriz = dados;
    @(posedge clk);
    fim_now = 1'b0;
    if (reset || !hab) begin
      running = 1'b0;
      t = 0;
    end else if (!running) begin
      running = 1'b1;
      t = 0;
      snap = dados;
    end else begin
      t++;
      if (t == FP) begin
        t = 0;
        snap = dados;
        fim_now = 1'b1;
      end
    end
    #1;
    if (vif.fim_quadro === 1'b1) pulses++;
    check_out();
  endtask

  task automatic wait_t(int target);
    int n;
    n = 0;
    while (!(running && t == target) && n < 100) begin
      tick(1'b1);
      n++;
    end
    chk("espera", 32'(running && t == target), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    dados = '0;
    vif.habilitar = 1'b0;
    vif.dados_matriz = '0;
    #2;
    check_out();
    tick(1'b0);
    tick(1'b0);
    reset = 1'b0;

    repeat (20) tick(1'b0);

    for (int c = 0; c < NC; c++)
      dados[c*NL +: NL] = NL'(1 << c);
    pulses = 0;
    repeat (1 + 3 * FP) tick(1'b1);
    chk("pulsos_3_quadros", 32'(pulses), 32'd3);

    wait_t(2 * CP + TA);
    dados = '1;
    repeat (2 * FP) tick(1'b1);

    wait_t(3 * CP + TA + 1);
    tick(1'b0);
    chk("queda_colunas", 32'(vif.colunas), 32'd0);
    chk("queda_fim", 32'(vif.fim_quadro), 32'd0);
    dados = {NB{1'b0}} | 35'h2A5A5A5A5;
    repeat (30) tick(1'b1);

    wait_t(CP + TA);
    #2 reset = 1'b1;
    running = 1'b0;
    t = 0;
    fim_now = 1'b0;
    #1 check_out();
    tick(1'b1);
    reset = 1'b0;
    repeat (30) tick(1'b1);

    repeat (400) begin
      if ($urandom_range(0, 9) == 0)
        dados = NB'({$urandom, $urandom});
      tick($urandom_range(0, 39) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
